ram_handshake_ctrl: RTL and testbench

//  Parametrised byte-addressed big-endian data/instruction memory with a four-phase MOV/MOC handshake.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_op_decode.sv | 57 +++++
 rtl/ram_handshake_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ram_handshake_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared opcodes, access sizes and FSM states for the
// handshaked byte-addressed memory.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [2:0] sz_bytes(input size_e s);
        case (s)
            SZ_H:    sz_bytes = 3'd2;
            SZ_W:    sz_bytes = 3'd4;
            default: sz_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Combinational opcode/address checker for a memory request.
// In: op, rw, addr. Out: size, sext, is_load, misaligned, out_of_range, bad_op.
module mem_op_decode
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 32
) (
    input  logic [5:0]        op,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    output size_e             size,
    output logic              sext,
    output logic              is_load,
    output logic              misaligned,
    output logic              out_of_range,
    output logic              bad_op
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic          known;
    logic [2:0]    nb;
    logic [AW:0]   last;

    always_comb begin
        size    = SZ_B;
        sext    = 1'b0;
        is_load = 1'b0;
        known   = 1'b1;
        case (op)
            OP_LB:  begin size = SZ_B; sext = 1'b1; is_load = 1'b1; end
            OP_LH:  begin size = SZ_H; sext = 1'b1; is_load = 1'b1; end
            OP_LW:  begin size = SZ_W; is_load = 1'b1; end
            OP_LBU: begin size = SZ_B; is_load = 1'b1; end
            OP_LHU: begin size = SZ_H; is_load = 1'b1; end
            OP_SB:  size = SZ_B;
            OP_SH:  size = SZ_H;
            OP_SW:  size = SZ_W;
            default: known = 1'b0;
        endcase
    end

    // RW must agree with the load/store class of the opcode
    assign bad_op = !known || (is_load != rw);

    assign misaligned = (size == SZ_H && addr[0]) ||
                        (size == SZ_W && addr[1:0] != 2'b00);

    assign nb   = sz_bytes(size);
    assign last = {1'b0, addr[AW-1:0]} + (AW+1)'(nb - 3'd1);

    // High address bits must be clear and the last byte must fit
    assign out_of_range = ((addr >> AW) != '0) ||
                          (last >= (AW+1)'(DEPTH_BYTES));

endmodule

// File: rtl/ram_handshake_ctrl.sv
// Big-endian byte memory behind a four-phase MOV/MOC handshake.
// In: Clk, Clr, MOV, RW, OP, Address, DataIn. Out: DataOut, MOC, Err.
module ram_handshake_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MOV,
    input  logic              RW,
    input  logic [5:0]        OP,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic              mem_we;

    logic [7:0] mem [0:DEPTH_BYTES-1];

    size_e size;
    logic  sext, is_load, misaligned, out_of_range, bad_op;
    logic  fault;

    mem_op_decode #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_dec (
        .op           (op_q),
        .rw           (rw_q),
        .addr         (addr_q),
        .size         (size),
        .sext         (sext),
        .is_load      (is_load),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .bad_op       (bad_op)
    );

    assign fault = misaligned || out_of_range || bad_op;

    // Byte lanes wrap within the array; wrapped lanes only
    // occur on requests already flagged out of range.
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_val;

    assign a0 = addr_q[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        case (size)
            SZ_B:    load_val = {{24{sext & b0[7]}}, b0};
            SZ_H:    load_val = {{16{sext & b0[7]}}, b0, b1};
            default: load_val = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    rw_d    = RW;
                    op_d    = OP;
                    addr_d  = Address;
                    din_d   = DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moc_d   = 1'b1;
                    state_d = S_DONE;
                    if (fault) begin
                        err_d  = 1'b1;
                        dout_d = '0;
                    end else if (is_load) begin
                        dout_d = load_val;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    // Array is never reset; writes land on the WAIT->DONE edge
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            case (size)
                SZ_B: mem[a0] <= din_q[7:0];
                SZ_H: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                default: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_ram_handshake_ctrl.sv
// Directed bench for ram_handshake_ctrl with a byte-level
// reference model; a second instance covers WAIT_CYCLES=0.
module tb_ram_handshake_ctrl;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam int DEPTH = 512;
    localparam int WC    = 2;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        MOV, RW;
    logic [5:0]  OP;
    logic [31:0] Address, DataIn, DataOut;
    logic        MOC, Err;

    logic        z_mov, z_rw;
    logic [5:0]  z_op;
    logic [31:0] z_addr, z_din, z_dout;
    logic        z_moc, z_err;

    always #5 Clk = ~Clk;

    ram_handshake_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WC), .ADDR_W(32)) dut (
        .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .OP(OP),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .Err(Err)
    );

    ram_handshake_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .Clk(Clk), .Clr(Clr), .MOV(z_mov), .RW(z_rw), .OP(z_op),
        .Address(z_addr), .DataIn(z_din), .DataOut(z_dout),
        .MOC(z_moc), .Err(z_err)
    );

    int n_chk = 0;
    int n_err = 0;

    bit          mon_en = 1'b0;
    bit          exp_moc = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_dout = '0;
    logic [7:0]  mem_m [DEPTH];
    logic        last_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference behaviour: legality from the opcode table and
    // byte-wise big-endian access on an array of bytes.
    task automatic model_apply(input logic [5:0] op, input bit rw,
                               input logic [31:0] a, input logic [31:0] din);
        int nb;
        bit ld, sg, bad;
        logic [31:0] v;
        longint la;
        nb = 0; ld = 0; sg = 0;
        case (op)
            LB:  begin nb = 1; ld = 1; sg = 1; end
            LH:  begin nb = 2; ld = 1; sg = 1; end
            LW:  begin nb = 4; ld = 1; end
            LBU: begin nb = 1; ld = 1; end
            LHU: begin nb = 2; ld = 1; end
            SB:  nb = 1;
            SH:  nb = 2;
            SW:  nb = 4;
            default: nb = 0;
        endcase
        la  = longint'(a);
        bad = (nb == 0) || (ld != rw);
        if (!bad) bad = (la % nb != 0) || (la + nb > DEPTH);
        exp_err = bad;
        if (bad) begin
            exp_dout = '0;
        end else if (ld) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_m[int'(la) + i]);
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            exp_dout = v;
        end else begin
            for (int i = 0; i < nb; i++)
                mem_m[int'(la) + i] = 8'(din >> (8*(nb-1-i)));
        end
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            chk("moc", {31'b0, MOC}, {31'b0, exp_moc});
            if (exp_moc) chk("err", {31'b0, Err}, {31'b0, exp_err});
            chk("dout", DataOut, exp_dout);
        end
    end

    task automatic run_op(input logic [5:0] op, input bit rw, input logic [31:0] a,
                          input logic [31:0] din, input int hold);
        @(negedge Clk);
        OP = op; RW = rw; Address = a; DataIn = din; MOV = 1'b1;
        @(posedge Clk); #1;
        OP = 6'h3F; RW = ~rw; Address = ~a; DataIn = ~din;
        repeat (WC) begin @(posedge Clk); #1; end
        @(posedge Clk); #1;
        model_apply(op, rw, a, din);
        exp_moc  = 1'b1;
        last_err = Err;
        repeat (hold) begin @(posedge Clk); #1; end
        MOV = 1'b0;
        @(posedge Clk); #1;
        exp_moc = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        Clr = 1'b1; MOV = 1'b0; RW = 1'b0; OP = '0; Address = '0; DataIn = '0;
        z_mov = 1'b0; z_rw = 1'b0; z_op = '0; z_addr = '0; z_din = '0;
        last_err = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_moc", {31'b0, MOC}, 32'h0);
        chk("rst_err", {31'b0, Err}, 32'h0);
        chk("rst_dout", DataOut, 32'h0);
        Clr = 1'b0;
        mon_en = 1'b1;

        run_op(SW, 0, 32'h010, 32'h8899AABB, 0);
        run_op(LW, 1, 32'h010, 0, 0);
        chk("lw10", DataOut, 32'h8899AABB);
        run_op(LBU, 1, 32'h011, 0, 0);
        chk("lbu11", DataOut, 32'h00000099);

        run_op(SH, 0, 32'h020, 32'h0000F00D, 0);
        run_op(LH, 1, 32'h020, 0, 0);
        chk("lh20", DataOut, 32'hFFFFF00D);
        run_op(LHU, 1, 32'h020, 0, 0);
        chk("lhu20", DataOut, 32'h0000F00D);
        run_op(LB, 1, 32'h021, 0, 0);
        chk("lb21", DataOut, 32'h0000000D);
        run_op(LB, 1, 32'h013, 0, 0);
        chk("lb13", DataOut, 32'hFFFFFFBB);
        run_op(SB, 0, 32'h012, 32'hFFFFFF5A, 0);
        chk("sb_keep", DataOut, 32'hFFFFFFBB);
        run_op(LW, 1, 32'h010, 0, 0);
        chk("lw10b", DataOut, 32'h88995ABB);

        run_op(LW, 1, 32'h012, 0, 0);
        chk("lw12_err", {31'b0, last_err}, 32'h1);
        chk("lw12_dout", DataOut, 32'h0);
        run_op(SW, 0, 32'h1FC, 32'hCAFEBABE, 0);
        run_op(SW, 0, 32'h1FE, 32'h12345678, 0);
        chk("sw1fe_err", {31'b0, last_err}, 32'h1);
        run_op(LW, 1, 32'h1FC, 0, 0);
        chk("lw1fc", DataOut, 32'hCAFEBABE);
        run_op(6'b000000, 1, 32'h010, 0, 0);
        chk("op0_err", {31'b0, last_err}, 32'h1);
        run_op(SB, 1, 32'h010, 0, 0);
        chk("sbrw_err", {31'b0, last_err}, 32'h1);
        run_op(LW, 0, 32'h010, 0, 0);
        run_op(LW, 1, 32'h200, 0, 0);
        run_op(LB, 1, 32'h80000010, 0, 0);
        chk("hi_err", {31'b0, last_err}, 32'h1);
        run_op(LB, 1, 32'h1FF, 0, 0);
        chk("lb1ff", DataOut, 32'hFFFFFFBE);

        run_op(SB, 0, 32'h030, 32'h000000A5, 6);
        run_op(LBU, 1, 32'h030, 0, 6);
        chk("hold", DataOut, 32'h000000A5);

        run_op(SW, 0, 32'h040, 32'h11223344, 0);
        @(negedge Clk);
        OP = SW; RW = 1'b0; Address = 32'h040; DataIn = 32'hDEADBEEF; MOV = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Clr = 1'b1;
        exp_moc = 1'b0; exp_err = 1'b0; exp_dout = '0;
        #1;
        chk("clr_dout", DataOut, 32'h0);
        chk("clr_moc", {31'b0, MOC}, 32'h0);
        @(negedge Clk);
        MOV = 1'b0;
        @(negedge Clk);
        Clr = 1'b0;
        run_op(LW, 1, 32'h040, 0, 0);
        chk("clr_lw40", DataOut, 32'h11223344);

        @(negedge Clk);
        z_op = SW; z_rw = 1'b0; z_addr = 32'h008; z_din = 32'h01020304; z_mov = 1'b1;
        @(posedge Clk); #1;
        z_addr = 32'h0; z_din = 32'h0;
        chk("z_sw_t", {31'b0, z_moc}, 32'h0);
        @(posedge Clk); #1;
        chk("z_sw_t1", {31'b0, z_moc}, 32'h1);
        chk("z_sw_err", {31'b0, z_err}, 32'h0);
        z_mov = 1'b0;
        @(posedge Clk); #1;
        chk("z_sw_idle", {31'b0, z_moc}, 32'h0);
        z_op = LW; z_rw = 1'b1; z_addr = 32'h008; z_mov = 1'b1;
        @(posedge Clk); #1;
        chk("z_lw_t", {31'b0, z_moc}, 32'h0);
        @(posedge Clk); #1;
        chk("z_lw_t1", {31'b0, z_moc}, 32'h1);
        chk("z_lw_dout", z_dout, 32'h01020304);
        z_mov = 1'b0;
        @(posedge Clk); #1;
        chk("z_lw_idle", {31'b0, z_moc}, 32'h0);

        @(negedge Clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
